// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and load/store.
// LS has priority, and a starvation guard protects IF. Define ARB_PERF_CNT_EN to add grant/conflict counters.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_ls_grants,
  output logic [31:0]       perf_conflicts
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic [3:0] starve_cnt;
  logic       win_ls;
  logic       lat_we;
  logic       grant_if;
  logic       grant_ls;

  // IF is forced through only once LS has starved it STARVE_MAX times in a row
  assign grant_if = if_req && (!ls_req || (starve_cnt == 4'(STARVE_MAX)));
  assign grant_ls = ls_req && !grant_if;

  assign stall = (if_req & ~if_ack) | (ls_req & ~ls_ack);

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    if_ack    = 1'b0;
    ls_ack    = 1'b0;
    case (state)
      IDLE:  if (if_req || ls_req) state_nxt = ISSUE;
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        state_nxt = WAIT;
      end
      WAIT:  if (wait_cnt == 4'd0) state_nxt = ACK;
      ACK: begin
        if_ack    = !win_ls;
        ls_ack    = win_ls;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latching happens only in IDLE, so the ACK cycle can never re-sample a request
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      starve_cnt <= 4'd0;
      win_ls     <= 1'b0;
      lat_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      ls_rdata   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_ls) begin
            win_ls    <= 1'b1;
            lat_we    <= ls_we;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
            if (if_req && (starve_cnt != 4'(STARVE_MAX)))
              starve_cnt <= starve_cnt + 4'd1;
          end else if (grant_if) begin
            win_ls     <= 1'b0;
            lat_we     <= 1'b0;
            mem_addr   <= if_addr;
            starve_cnt <= 4'd0;
          end
        end
        ISSUE: wait_cnt <= 4'(MEM_LAT - 1);
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            if (!win_ls)
              if_rdata <= mem_rdata;
            else if (!lat_we)
              ls_rdata <= mem_rdata;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_if_grants <= 32'd0;
      perf_ls_grants <= 32'd0;
      perf_conflicts <= 32'd0;
    end else if (state == IDLE) begin
      if (grant_if) perf_if_grants <= perf_if_grants + 32'd1;
      if (grant_ls) perf_ls_grants <= perf_ls_grants + 32'd1;
      if (if_req && ls_req) perf_conflicts <= perf_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level reference model plus fixed-latency memory model.
// Honours ARB_PERF_CNT_EN when the design is built with it.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic              clk, reset;
  logic              if_req, ls_req, ls_we;
  logic [ADDR_W-1:0] if_addr, ls_addr;
  logic [DATA_W-1:0] ls_wdata, mem_rdata;
  logic [DATA_W-1:0] if_rdata, ls_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              if_ack, ls_ack, mem_en, mem_we, stall;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]       perf_if_grants, perf_ls_grants, perf_conflicts;
`endif

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdata(ls_rdata), .ls_ack(ls_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_grants(perf_if_grants), .perf_ls_grants(perf_ls_grants), .perf_conflicts(perf_conflicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory model: read data appears exactly MEM_LAT cycles after the mem_en cycle, noise otherwise
  logic [31:0] mem [0:63];
  int          rd_cnt = 0;
  logic [31:0] rd_data;

  function automatic int idx(input logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) mem[idx(mem_addr)] = mem_wdata;
      else begin
        rd_cnt  = MEM_LAT;
        rd_data = mem[idx(mem_addr)];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rd_cnt > 0) begin
      rd_cnt--;
      mem_rdata = (rd_cnt == 0) ? rd_data : $urandom;
    end else begin
      mem_rdata = $urandom;
    end
  end

  // Reference model: one transaction at a time, each occupying MEM_LAT+3 cycles from its IDLE decision
  int          cyc = 0;
  bit          rst_prev = 1'b1;
  bit          txn = 1'b0;
  int          g, next_idle = 0, starve = 0;
  bit          w_ls, w_we;
  logic [31:0] w_addr, w_wdata;
  logic        e_mem_en, e_mem_we, e_if_ack, e_ls_ack, e_stall;
  logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_ls_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] p_if, p_ls, p_conf;
`endif

  task automatic model_expect();
    @(negedge clk);
    cyc++;
    if (rst_prev) begin
      txn = 1'b0; next_idle = cyc; starve = 0;
      e_if_rdata = '0; e_ls_rdata = '0; e_mem_addr = '0; e_mem_wdata = '0;
`ifdef ARB_PERF_CNT_EN
      p_if = '0; p_ls = '0; p_conf = '0;
`endif
    end
    e_mem_en = 1'b0; e_mem_we = 1'b0; e_if_ack = 1'b0; e_ls_ack = 1'b0;
    if (txn && cyc == g + 1) begin
      e_mem_en = 1'b1; e_mem_we = w_we; e_mem_addr = w_addr;
      if (w_ls) e_mem_wdata = w_wdata;
    end
    if (txn && cyc == g + MEM_LAT + 2) begin
      if (w_ls) begin
        e_ls_ack = 1'b1;
        if (!w_we) e_ls_rdata = mem[idx(w_addr)];
      end else begin
        e_if_ack = 1'b1;
        e_if_rdata = mem[idx(w_addr)];
      end
      txn = 1'b0;
    end
    e_stall = (if_req & ~e_if_ack) | (ls_req & ~e_ls_ack);
  endtask

  task automatic model_decide();
    if (reset) begin
      rst_prev = 1'b1;
      return;
    end
    rst_prev = 1'b0;
    if (cyc != next_idle) return;
    if (!if_req && !ls_req) begin
      next_idle = cyc + 1;
      return;
    end
`ifdef ARB_PERF_CNT_EN
    if (if_req && ls_req) p_conf++;
`endif
    txn = 1'b1; g = cyc; next_idle = cyc + MEM_LAT + 3;
    if (ls_req && !(if_req && starve == STARVE_MAX)) begin
      w_ls = 1'b1; w_we = ls_we; w_addr = ls_addr; w_wdata = ls_wdata;
      if (if_req && starve < STARVE_MAX) starve++;
`ifdef ARB_PERF_CNT_EN
      p_ls++;
`endif
    end else begin
      w_ls = 1'b0; w_we = 1'b0; w_addr = if_addr; w_wdata = '0;
      starve = 0;
`ifdef ARB_PERF_CNT_EN
      p_if++;
`endif
    end
  endtask

  // Requesters hold their request until the acknowledging cycle, then may drop or issue a new one
  task automatic req_update(input bit want_if, input bit want_ls);
    if (e_if_ack || if_req !== 1'b1) begin
      if_req = want_if;
      if (want_if) if_addr = {24'h0, 6'($urandom), 2'b00};
    end
    if (e_ls_ack || ls_req !== 1'b1) begin
      ls_req = want_ls;
      if (want_ls) begin
        ls_we    = 1'($urandom);
        ls_addr  = {24'h0, 6'($urandom), 2'b00};
        ls_wdata = $urandom;
      end
    end
  endtask

  task automatic test_reset();
    string tag = "reset";
    int first_en = -1;
    int release_cyc = -1;
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200; ls_wdata = 32'h0;
    for (int c = 0; c < 15; c++) begin
      model_expect();
      checks++; if (mem_en !== e_mem_en) begin errors++; $display("[TB] FAIL %s mem_en cyc=%0d got=%b exp=%b", tag, cyc, mem_en, e_mem_en); end
      checks++; if (mem_we !== e_mem_we) begin errors++; $display("[TB] FAIL %s mem_we cyc=%0d got=%b exp=%b", tag, cyc, mem_we, e_mem_we); end
      checks++; if (mem_addr !== e_mem_addr) begin errors++; $display("[TB] FAIL %s mem_addr cyc=%0d got=%h exp=%h", tag, cyc, mem_addr, e_mem_addr); end
      if (e_mem_en && e_mem_we) begin checks++; if (mem_wdata !== e_mem_wdata) begin errors++; $display("[TB] FAIL %s mem_wdata cyc=%0d got=%h exp=%h", tag, cyc, mem_wdata, e_mem_wdata); end end
      checks++; if (if_ack !== e_if_ack) begin errors++; $display("[TB] FAIL %s if_ack cyc=%0d got=%b exp=%b", tag, cyc, if_ack, e_if_ack); end
      checks++; if (ls_ack !== e_ls_ack) begin errors++; $display("[TB] FAIL %s ls_ack cyc=%0d got=%b exp=%b", tag, cyc, ls_ack, e_ls_ack); end
      checks++; if (if_rdata !== e_if_rdata) begin errors++; $display("[TB] FAIL %s if_rdata cyc=%0d got=%h exp=%h", tag, cyc, if_rdata, e_if_rdata); end
      checks++; if (ls_rdata !== e_ls_rdata) begin errors++; $display("[TB] FAIL %s ls_rdata cyc=%0d got=%h exp=%h", tag, cyc, ls_rdata, e_ls_rdata); end
      checks++; if (stall !== e_stall) begin errors++; $display("[TB] FAIL %s stall cyc=%0d got=%b exp=%b", tag, cyc, stall, e_stall); end
      if (mem_en === 1'b1 && first_en < 0 && release_cyc >= 0) first_en = cyc;
      if (c == 2) begin
        reset = 1'b0;
        release_cyc = cyc;
      end else if (c > 2) begin
        req_update(1'b0, 1'b0);
      end
      model_decide();
    end
    checks++;
    if (first_en != release_cyc + 1) begin
      errors++;
      $display("[TB] FAIL reset first_mem_en cycle got=%0d exp=%0d", first_en, release_cyc + 1);
    end
  endtask

  task automatic test_if_fetch();
    string tag = "fetch";
    int sample_cyc = 0, ack_cyc = -1, en_count = 0;
    logic [31:0] got = '0;
    mem[idx(32'h10)] = 32'h8C220004;
    for (int c = 0; c < 8; c++) begin
      model_expect();
      checks++; if (mem_en !== e_mem_en) begin errors++; $display("[TB] FAIL %s mem_en cyc=%0d got=%b exp=%b", tag, cyc, mem_en, e_mem_en); end
      checks++; if (mem_we !== e_mem_we) begin errors++; $display("[TB] FAIL %s mem_we cyc=%0d got=%b exp=%b", tag, cyc, mem_we, e_mem_we); end
      checks++; if (mem_addr !== e_mem_addr) begin errors++; $display("[TB] FAIL %s mem_addr cyc=%0d got=%h exp=%h", tag, cyc, mem_addr, e_mem_addr); end
      checks++; if (if_ack !== e_if_ack) begin errors++; $display("[TB] FAIL %s if_ack cyc=%0d got=%b exp=%b", tag, cyc, if_ack, e_if_ack); end
      checks++; if (ls_ack !== e_ls_ack) begin errors++; $display("[TB] FAIL %s ls_ack cyc=%0d got=%b exp=%b", tag, cyc, ls_ack, e_ls_ack); end
      checks++; if (if_rdata !== e_if_rdata) begin errors++; $display("[TB] FAIL %s if_rdata cyc=%0d got=%h exp=%h", tag, cyc, if_rdata, e_if_rdata); end
      checks++; if (stall !== e_stall) begin errors++; $display("[TB] FAIL %s stall cyc=%0d got=%b exp=%b", tag, cyc, stall, e_stall); end
      if (mem_en === 1'b1) en_count++;
      if (if_ack === 1'b1 && ack_cyc < 0) begin ack_cyc = cyc; got = if_rdata; end
      if (c == 0) begin
        if_req = 1'b1; if_addr = 32'h10; ls_req = 1'b0;
        sample_cyc = cyc;
      end else begin
        req_update(1'b0, 1'b0);
      end
      model_decide();
    end
    checks++; if (en_count != 1) begin errors++; $display("[TB] FAIL fetch mem_en_cycles got=%0d exp=1", en_count); end
    checks++; if (ack_cyc - sample_cyc != 4) begin errors++; $display("[TB] FAIL fetch ack_latency got=%0d exp=4", ack_cyc - sample_cyc); end
    checks++; if (got !== 32'h8C220004) begin errors++; $display("[TB] FAIL fetch if_rdata_at_ack got=%h exp=8c220004", got); end
  endtask

  task automatic test_store();
    string tag = "store";
    int ack_count = 0, wr_count = 0;
    logic [31:0] prev_ls = e_ls_rdata;
    for (int c = 0; c < 8; c++) begin
      model_expect();
      checks++; if (mem_en !== e_mem_en) begin errors++; $display("[TB] FAIL %s mem_en cyc=%0d got=%b exp=%b", tag, cyc, mem_en, e_mem_en); end
      checks++; if (mem_we !== e_mem_we) begin errors++; $display("[TB] FAIL %s mem_we cyc=%0d got=%b exp=%b", tag, cyc, mem_we, e_mem_we); end
      checks++; if (mem_addr !== e_mem_addr) begin errors++; $display("[TB] FAIL %s mem_addr cyc=%0d got=%h exp=%h", tag, cyc, mem_addr, e_mem_addr); end
      if (e_mem_en && e_mem_we) begin checks++; if (mem_wdata !== e_mem_wdata) begin errors++; $display("[TB] FAIL %s mem_wdata cyc=%0d got=%h exp=%h", tag, cyc, mem_wdata, e_mem_wdata); end end
      checks++; if (ls_ack !== e_ls_ack) begin errors++; $display("[TB] FAIL %s ls_ack cyc=%0d got=%b exp=%b", tag, cyc, ls_ack, e_ls_ack); end
      checks++; if (ls_rdata !== e_ls_rdata) begin errors++; $display("[TB] FAIL %s ls_rdata cyc=%0d got=%h exp=%h", tag, cyc, ls_rdata, e_ls_rdata); end
      checks++; if (stall !== e_stall) begin errors++; $display("[TB] FAIL %s stall cyc=%0d got=%b exp=%b", tag, cyc, stall, e_stall); end
      if (ls_ack === 1'b1) ack_count++;
      if (mem_en === 1'b1 && mem_we === 1'b1 && mem_addr === 32'h40 && mem_wdata === 32'hDEADBEEF) wr_count++;
      if (c == 0) begin
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'hDEADBEEF; if_req = 1'b0;
      end else begin
        req_update(1'b0, 1'b0);
      end
      model_decide();
    end
    checks++; if (ack_count != 1) begin errors++; $display("[TB] FAIL store ls_ack_pulses got=%0d exp=1", ack_count); end
    checks++; if (wr_count != 1) begin errors++; $display("[TB] FAIL store write_strobes got=%0d exp=1", wr_count); end
    checks++; if (ls_rdata !== prev_ls) begin errors++; $display("[TB] FAIL store ls_rdata_kept got=%h exp=%h", ls_rdata, prev_ls); end
  endtask

  task automatic test_simultaneous();
    string tag = "simul";
    int ls_cyc = -1, if_cyc = -1, ls_n = 0, if_n = 0;
    for (int c = 0; c < 14; c++) begin
      model_expect();
      checks++; if (mem_en !== e_mem_en) begin errors++; $display("[TB] FAIL %s mem_en cyc=%0d got=%b exp=%b", tag, cyc, mem_en, e_mem_en); end
      checks++; if (mem_addr !== e_mem_addr) begin errors++; $display("[TB] FAIL %s mem_addr cyc=%0d got=%h exp=%h", tag, cyc, mem_addr, e_mem_addr); end
      checks++; if (if_ack !== e_if_ack) begin errors++; $display("[TB] FAIL %s if_ack cyc=%0d got=%b exp=%b", tag, cyc, if_ack, e_if_ack); end
      checks++; if (ls_ack !== e_ls_ack) begin errors++; $display("[TB] FAIL %s ls_ack cyc=%0d got=%b exp=%b", tag, cyc, ls_ack, e_ls_ack); end
      checks++; if (if_rdata !== e_if_rdata) begin errors++; $display("[TB] FAIL %s if_rdata cyc=%0d got=%h exp=%h", tag, cyc, if_rdata, e_if_rdata); end
      checks++; if (ls_rdata !== e_ls_rdata) begin errors++; $display("[TB] FAIL %s ls_rdata cyc=%0d got=%h exp=%h", tag, cyc, ls_rdata, e_ls_rdata); end
      checks++; if (stall !== e_stall) begin errors++; $display("[TB] FAIL %s stall cyc=%0d got=%b exp=%b", tag, cyc, stall, e_stall); end
      if (ls_ack === 1'b1) begin ls_n++; if (ls_cyc < 0) ls_cyc = cyc; end
      if (if_ack === 1'b1) begin if_n++; if (if_cyc < 0) if_cyc = cyc; end
      if (c == 0) begin
        if_req = 1'b1; if_addr = 32'h20;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h30;
      end else begin
        req_update(1'b0, 1'b0);
      end
      model_decide();
    end
    checks++; if (if_cyc - ls_cyc != MEM_LAT + 3) begin errors++; $display("[TB] FAIL simul ack_spacing got=%0d exp=%0d", if_cyc - ls_cyc, MEM_LAT + 3); end
    checks++; if (ls_n != 1 || if_n != 1) begin errors++; $display("[TB] FAIL simul ack_counts got=ls%0d/if%0d exp=ls1/if1", ls_n, if_n); end
  endtask

  task automatic test_starvation();
    string tag = "starve";
    int ls_before = 0, ls_after = 0, if_n = 0;
    for (int c = 0; c < 45; c++) begin
      model_expect();
      checks++; if (mem_en !== e_mem_en) begin errors++; $display("[TB] FAIL %s mem_en cyc=%0d got=%b exp=%b", tag, cyc, mem_en, e_mem_en); end
      checks++; if (mem_addr !== e_mem_addr) begin errors++; $display("[TB] FAIL %s mem_addr cyc=%0d got=%h exp=%h", tag, cyc, mem_addr, e_mem_addr); end
      checks++; if (if_ack !== e_if_ack) begin errors++; $display("[TB] FAIL %s if_ack cyc=%0d got=%b exp=%b", tag, cyc, if_ack, e_if_ack); end
      checks++; if (ls_ack !== e_ls_ack) begin errors++; $display("[TB] FAIL %s ls_ack cyc=%0d got=%b exp=%b", tag, cyc, ls_ack, e_ls_ack); end
      checks++; if (ls_rdata !== e_ls_rdata) begin errors++; $display("[TB] FAIL %s ls_rdata cyc=%0d got=%h exp=%h", tag, cyc, ls_rdata, e_ls_rdata); end
      checks++; if (stall !== e_stall) begin errors++; $display("[TB] FAIL %s stall cyc=%0d got=%b exp=%b", tag, cyc, stall, e_stall); end
      if (if_ack === 1'b1) if_n++;
      if (ls_ack === 1'b1) begin
        if (if_n == 0) ls_before++; else ls_after++;
      end
      if (c == 0) begin
        if_req = 1'b1; if_addr = 32'h50;
        ls_req = 1'b1; ls_we = 1'($urandom); ls_addr = 32'h60; ls_wdata = $urandom;
      end else begin
        req_update(1'b0, 1'b1);
      end
      model_decide();
    end
    checks++; if (ls_before != STARVE_MAX) begin errors++; $display("[TB] FAIL starve ls_grants_before_if got=%0d exp=%0d", ls_before, STARVE_MAX); end
    checks++; if (if_n != 1) begin errors++; $display("[TB] FAIL starve if_grants got=%0d exp=1", if_n); end
    checks++; if (ls_after < 1) begin errors++; $display("[TB] FAIL starve ls_resumed got=%0d exp>=1", ls_after); end
  endtask

  task automatic test_random();
    string tag = "random";
    for (int c = 0; c < 420; c++) begin
      model_expect();
      checks++; if (mem_en !== e_mem_en) begin errors++; $display("[TB] FAIL %s mem_en cyc=%0d got=%b exp=%b", tag, cyc, mem_en, e_mem_en); end
      checks++; if (mem_we !== e_mem_we) begin errors++; $display("[TB] FAIL %s mem_we cyc=%0d got=%b exp=%b", tag, cyc, mem_we, e_mem_we); end
      checks++; if (mem_addr !== e_mem_addr) begin errors++; $display("[TB] FAIL %s mem_addr cyc=%0d got=%h exp=%h", tag, cyc, mem_addr, e_mem_addr); end
      if (e_mem_en && e_mem_we) begin checks++; if (mem_wdata !== e_mem_wdata) begin errors++; $display("[TB] FAIL %s mem_wdata cyc=%0d got=%h exp=%h", tag, cyc, mem_wdata, e_mem_wdata); end end
      checks++; if (if_ack !== e_if_ack) begin errors++; $display("[TB] FAIL %s if_ack cyc=%0d got=%b exp=%b", tag, cyc, if_ack, e_if_ack); end
      checks++; if (ls_ack !== e_ls_ack) begin errors++; $display("[TB] FAIL %s ls_ack cyc=%0d got=%b exp=%b", tag, cyc, ls_ack, e_ls_ack); end
      checks++; if (if_rdata !== e_if_rdata) begin errors++; $display("[TB] FAIL %s if_rdata cyc=%0d got=%h exp=%h", tag, cyc, if_rdata, e_if_rdata); end
      checks++; if (ls_rdata !== e_ls_rdata) begin errors++; $display("[TB] FAIL %s ls_rdata cyc=%0d got=%h exp=%h", tag, cyc, ls_rdata, e_ls_rdata); end
      checks++; if (stall !== e_stall) begin errors++; $display("[TB] FAIL %s stall cyc=%0d got=%b exp=%b", tag, cyc, stall, e_stall); end
      req_update((c < 400) && ($urandom_range(0, 3) != 0), (c < 400) && ($urandom_range(0, 2) != 0));
      model_decide();
    end
`ifdef ARB_PERF_CNT_EN
    checks++; if (perf_if_grants !== p_if) begin errors++; $display("[TB] FAIL random perf_if got=%0d exp=%0d", perf_if_grants, p_if); end
    checks++; if (perf_ls_grants !== p_ls) begin errors++; $display("[TB] FAIL random perf_ls got=%0d exp=%0d", perf_ls_grants, p_ls); end
    checks++; if (perf_conflicts !== p_conf) begin errors++; $display("[TB] FAIL random perf_conf got=%0d exp=%0d", perf_conflicts, p_conf); end
`endif
  endtask

  task automatic test_reset_mid();
    string tag = "rstmid";
    int ack_n = 0;
    bit done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      model_expect();
      checks++; if (mem_en !== e_mem_en) begin errors++; $display("[TB] FAIL %s mem_en cyc=%0d got=%b exp=%b", tag, cyc, mem_en, e_mem_en); end
      checks++; if (mem_we !== e_mem_we) begin errors++; $display("[TB] FAIL %s mem_we cyc=%0d got=%b exp=%b", tag, cyc, mem_we, e_mem_we); end
      checks++; if (mem_addr !== e_mem_addr) begin errors++; $display("[TB] FAIL %s mem_addr cyc=%0d got=%h exp=%h", tag, cyc, mem_addr, e_mem_addr); end
      checks++; if (ls_ack !== e_ls_ack) begin errors++; $display("[TB] FAIL %s ls_ack cyc=%0d got=%b exp=%b", tag, cyc, ls_ack, e_ls_ack); end
      checks++; if (if_rdata !== e_if_rdata) begin errors++; $display("[TB] FAIL %s if_rdata cyc=%0d got=%h exp=%h", tag, cyc, if_rdata, e_if_rdata); end
      checks++; if (ls_rdata !== e_ls_rdata) begin errors++; $display("[TB] FAIL %s ls_rdata cyc=%0d got=%h exp=%h", tag, cyc, ls_rdata, e_ls_rdata); end
      checks++; if (stall !== e_stall) begin errors++; $display("[TB] FAIL %s stall cyc=%0d got=%b exp=%b", tag, cyc, stall, e_stall); end
`ifdef ARB_PERF_CNT_EN
      checks++; if (perf_ls_grants !== p_ls || perf_if_grants !== p_if || perf_conflicts !== p_conf) begin errors++; $display("[TB] FAIL %s perf cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", tag, cyc, perf_if_grants, perf_ls_grants, perf_conflicts, p_if, p_ls, p_conf); end
`endif
      if (ls_ack === 1'b1) ack_n++;
      reset = 1'b0;
      if (c == 0) begin
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h80; if_req = 1'b0;
      end else if (!done && txn && cyc == g + 2) begin
        reset = 1'b1; ls_req = 1'b0; done = 1'b1;
      end
      model_decide();
    end
    checks++; if (ack_n != 0) begin errors++; $display("[TB] FAIL rstmid ls_ack_pulses got=%0d exp=0", ack_n); end
    checks++; if (!done) begin errors++; $display("[TB] FAIL rstmid reset_in_wait got=0 exp=1"); end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    reset = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0;
    $display("[TB] mem_port_arbiter bench, MEM_LAT=%0d STARVE_MAX=%0d", MEM_LAT, STARVE_MAX);
    test_reset();
    test_if_fetch();
    test_store();
    test_simultaneous();
    test_starvation();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
